// File: rtl/alu_exec.sv
// alu_exec - execute stage that feeds the register file write ports.
//
// Accepts one decoded R-type operation per in_valid/in_ready handshake and
// produces a result (written to rs) and a carry/extension byte (written to
// the dedicated COUT register). Single-cycle ops complete in the accept
// cycle; MUL runs a DW-step shift-add and holds in_ready low meanwhile.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_valid    operation offered
//   in_ready    stage can accept (high only while IDLE)
//   op          opcode: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 MUL,8 MOV,9-15 NOP
//   rs_addr     destination register (also left-operand source)
//   rs_val      left operand
//   rt_val      right operand
//   wb_we       one-cycle write pulse for wb_data -> rs
//   wb_cout_we  one-cycle write pulse for wb_cout -> COUT
//   wb_addr     write address
//   wb_data     result value
//   wb_cout     carry/extension value
module alu_exec #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op,
  input  logic [AW-1:0] rs_addr,
  input  logic [DW-1:0] rs_val,
  input  logic [DW-1:0] rt_val,
  output logic          wb_we,
  output logic          wb_cout_we,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic [DW-1:0] wb_cout
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, state_next;

  logic [CW-1:0]   cnt;
  logic [DW-1:0]   mcand;
  logic [DW-1:0]   mplier;
  logic [AW-1:0]   mul_addr;
  logic [2*DW-1:0] acc;
  logic [2*DW-1:0] acc_step;
  logic            mul_last;

  logic [DW-1:0]   alu_data;
  logic [DW-1:0]   alu_cout;
  logic            alu_we;
  logic            alu_cout_we;

  logic [DW:0]     sum;
  logic [DW:0]     diff;
  logic [2:0]      sh;
  logic [2*DW-1:0] sll_ext;
  logic [2*DW-1:0] srl_ext;

  logic            accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign mul_last = (cnt == CW'(DW - 1));

  // Shift-add step: add the multiplicand, weighted by the current bit
  // position, when that multiplier bit is set.
  assign acc_step = acc + (mplier[cnt] ? ({{DW{1'b0}}, mcand} << cnt) : '0);

  // Single-cycle result. Shifts are done on a double-width word so the
  // bits pushed out land in the other half, giving cout directly; a zero
  // shift leaves that half empty.
  always_comb begin
    sum         = {1'b0, rs_val} + {1'b0, rt_val};
    diff        = {1'b0, rs_val} - {1'b0, rt_val};
    sh          = rt_val[2:0];
    sll_ext     = {{DW{1'b0}}, rs_val} << sh;
    srl_ext     = {rs_val, {DW{1'b0}}} >> sh;
    alu_data    = '0;
    alu_cout    = '0;
    alu_we      = 1'b1;
    alu_cout_we = 1'b1;
    case (op)
      OP_ADD: begin
        alu_data = sum[DW-1:0];
        alu_cout = {{(DW-1){1'b0}}, sum[DW]};
      end
      OP_SUB: begin
        alu_data = diff[DW-1:0];
        alu_cout = {{(DW-1){1'b0}}, diff[DW]};
      end
      OP_AND: alu_data = rs_val & rt_val;
      OP_OR:  alu_data = rs_val | rt_val;
      OP_XOR: alu_data = rs_val ^ rt_val;
      OP_SLL: begin
        alu_data = sll_ext[DW-1:0];
        alu_cout = sll_ext[2*DW-1:DW];
      end
      OP_SRL: begin
        alu_data = srl_ext[2*DW-1:DW];
        alu_cout = srl_ext[DW-1:0];
      end
      OP_MOV: begin
        alu_data    = rt_val;
        alu_cout_we = 1'b0;
      end
      default: begin
        alu_we      = 1'b0;
        alu_cout_we = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && op == OP_MUL) state_next = MUL;
      MUL:     if (mul_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      mul_addr   <= '0;
      acc        <= '0;
      wb_we      <= 1'b0;
      wb_cout_we <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      wb_cout    <= '0;
    end else begin
      wb_we      <= 1'b0;
      wb_cout_we <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand    <= rs_val;
            mplier   <= rt_val;
            mul_addr <= rs_addr;
            acc      <= '0;
            cnt      <= '0;
          end else if (alu_we) begin
            wb_we      <= 1'b1;
            wb_cout_we <= alu_cout_we;
            wb_addr    <= rs_addr;
            wb_data    <= alu_data;
            if (alu_cout_we) wb_cout <= alu_cout;
          end
        end
      end else begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
        if (mul_last) begin
          cnt        <= '0;
          wb_we      <= 1'b1;
          wb_cout_we <= 1'b1;
          wb_addr    <= mul_addr;
          wb_data    <= acc_step[DW-1:0];
          wb_cout    <= acc_step[2*DW-1:DW];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios plus a random
// stream, with a scoreboard queue of expected write pulses.
module tb_alu_exec;
  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [AW-1:0] rs_addr;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic          wb_we;
  logic          wb_cout_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] wb_cout;

  alu_exec #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs_addr(rs_addr), .rs_val(rs_val), .rt_val(rt_val),
    .wb_we(wb_we), .wb_cout_we(wb_cout_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_cout(wb_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] cout;
    logic          cout_we;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_cout = '0;

  function automatic exp_t model(input logic [3:0] o, input logic [AW-1:0] a,
                                 input logic [DW-1:0] x, input logic [DW-1:0] y,
                                 input logic [DW-1:0] prev_cout);
    exp_t e;
    int xi, yi, sh, r, c;
    xi = int'(x);
    yi = int'(y);
    sh = int'(y[2:0]);
    r = 0;
    c = 0;
    e.cout_we = 1'b1;
    case (o)
      4'd0: begin r = xi + yi; c = r >> 8; end
      4'd1: begin r = xi - yi; c = (xi < yi) ? 1 : 0; end
      4'd2: r = xi & yi;
      4'd3: r = xi | yi;
      4'd4: r = xi ^ yi;
      4'd5: begin r = xi << sh; c = (sh == 0) ? 0 : (xi >> (8 - sh)); end
      4'd6: begin r = xi >> sh; c = (sh == 0) ? 0 : ((xi << (8 - sh)) & 255); end
      4'd7: begin r = xi * yi; c = r >> 8; end
      default: begin r = yi; c = int'(prev_cout); e.cout_we = 1'b0; end
    endcase
    e.addr = a;
    e.data = r[7:0];
    e.cout = c[7:0];
    return e;
  endfunction

  task automatic push_exp(input logic [3:0] o, input logic [AW-1:0] a,
                          input logic [DW-1:0] x, input logic [DW-1:0] y);
    exp_t e;
    if (o <= 4'd8) begin
      e = model(o, a, x, y, model_cout);
      sb.push_back(e);
      model_cout = e.cout;
    end
  endtask

  // Offer one op at a negedge, wait (bounded) for acceptance, drop valid
  // just after the accepting edge.
  task automatic offer(input logic [3:0] o, input logic [AW-1:0] a,
                       input logic [DW-1:0] x, input logic [DW-1:0] y);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; op = o; rs_addr = a; rs_val = x; rt_val = y;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
    end else begin
      push_exp(o, a, x, y);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (wb_we === 1'b1 || wb_cout_we === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_pulse: we=%b cwe=%b addr=%0d data=%h cout=%h, required no pulse",
                 wb_we, wb_cout_we, wb_addr, wb_data, wb_cout);
      end else begin
        mon_e = sb.pop_front();
        if (wb_we !== 1'b1 || wb_cout_we !== mon_e.cout_we || wb_addr !== mon_e.addr ||
            wb_data !== mon_e.data || wb_cout !== mon_e.cout) begin
          errors++;
          $display("FAIL sb_pulse: got we=%b cwe=%b addr=%0d data=%h cout=%h, required we=1 cwe=%b addr=%0d data=%h cout=%h",
                   wb_we, wb_cout_we, wb_addr, wb_data, wb_cout,
                   mon_e.cout_we, mon_e.addr, mon_e.data, mon_e.cout);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; op = '0; rs_addr = '0; rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wb_we, wb_cout_we, wb_addr, wb_data, wb_cout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b cwe=%b addr=%0d data=%h cout=%h, required all 0",
               wb_we, wb_cout_we, wb_addr, wb_data, wb_cout);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_add();
    offer(4'd0, 2'd2, 8'hF0, 8'h20);
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b1 || wb_cout_we !== 1'b1 || wb_addr !== 2'd2 ||
        wb_data !== 8'h10 || wb_cout !== 8'h01) begin
      errors++;
      $display("FAIL add_pulse: we=%b cwe=%b addr=%0d data=%h cout=%h, required 1 1 2 10 01",
               wb_we, wb_cout_we, wb_addr, wb_data, wb_cout);
    end
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b0 || wb_cout_we !== 1'b0) begin
      errors++;
      $display("FAIL add_pulse_width: we=%b cwe=%b, required 0 0", wb_we, wb_cout_we);
    end
  endtask

  task automatic test_sub_shift();
    logic [3:0]    ops[3]  = '{4'd1, 4'd5, 4'd6};
    logic [DW-1:0] xs[3]   = '{8'h05, 8'h81, 8'h81};
    logic [DW-1:0] ys[3]   = '{8'h07, 8'h09, 8'h01};
    logic [DW-1:0] ed[3]   = '{8'hFE, 8'h02, 8'h40};
    logic [DW-1:0] ec[3]   = '{8'h01, 8'h01, 8'h80};
    for (int i = 0; i < 3; i++) begin
      offer(ops[i], 2'd1, xs[i], ys[i]);
      @(negedge clk);
      checks++;
      if (wb_we !== 1'b1 || wb_data !== ed[i] || wb_cout !== ec[i]) begin
        errors++;
        $display("FAIL sub_shift_%0d: we=%b data=%h cout=%h, required we=1 data=%h cout=%h",
                 i, wb_we, wb_data, wb_cout, ed[i], ec[i]);
      end
    end
  endtask

  task automatic test_mul_held();
    int low;
    offer(4'd7, 2'd1, 8'hFF, 8'hFF);
    // Operands change right after acceptance; an ADD is held pending.
    op = 4'd0; rs_addr = 2'd3; rs_val = 8'h00; rt_val = 8'h00; in_valid = 1'b1;
    @(negedge clk);
    low = 0;
    while (!in_ready && low < 50) begin
      low++;
      @(negedge clk);
    end
    checks++;
    if (low != 8) begin
      errors++;
      $display("FAIL mul_ready_low: low cycles=%0d, required 8", low);
    end
    checks++;
    if (wb_we !== 1'b1 || wb_cout_we !== 1'b1 || wb_addr !== 2'd1 ||
        wb_data !== 8'h01 || wb_cout !== 8'hFE) begin
      errors++;
      $display("FAIL mul_pulse: we=%b cwe=%b addr=%0d data=%h cout=%h, required 1 1 1 01 FE",
               wb_we, wb_cout_we, wb_addr, wb_data, wb_cout);
    end
    push_exp(4'd0, 2'd3, 8'h00, 8'h00);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b1 || wb_addr !== 2'd3 || wb_data !== 8'h00 || wb_cout !== 8'h00) begin
      errors++;
      $display("FAIL held_add_pulse: we=%b addr=%0d data=%h cout=%h, required 1 3 00 00",
               wb_we, wb_addr, wb_data, wb_cout);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; rs_addr = 2'd0; rs_val = 8'h01; rt_val = 8'h01;
    push_exp(4'd0, 2'd0, 8'h01, 8'h01);
    @(posedge clk);
    #1 op = 4'd4; rs_addr = 2'd1; rs_val = 8'hFF; rt_val = 8'h0F;
    push_exp(4'd4, 2'd1, 8'hFF, 8'h0F);
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b1 || wb_cout_we !== 1'b1 || wb_data !== 8'h02) begin
      errors++;
      $display("FAIL b2b_add: we=%b cwe=%b data=%h, required 1 1 02", wb_we, wb_cout_we, wb_data);
    end
    @(posedge clk);
    #1 op = 4'd8; rs_addr = 2'd2; rs_val = 8'h33; rt_val = 8'h5A;
    push_exp(4'd8, 2'd2, 8'h33, 8'h5A);
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b1 || wb_cout_we !== 1'b1 || wb_data !== 8'hF0) begin
      errors++;
      $display("FAIL b2b_xor: we=%b cwe=%b data=%h, required 1 1 F0", wb_we, wb_cout_we, wb_data);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b1 || wb_cout_we !== 1'b0 || wb_data !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_mov: we=%b cwe=%b data=%h, required 1 0 5A", wb_we, wb_cout_we, wb_data);
    end
  endtask

  task automatic test_nop();
    logic [DW-1:0] d, c;
    logic [AW-1:0] a;
    d = wb_data; c = wb_cout; a = wb_addr;
    offer(4'hF, 2'd3, 8'hAA, 8'h55);
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b0 || wb_cout_we !== 1'b0 || wb_data !== d || wb_cout !== c || wb_addr !== a) begin
      errors++;
      $display("FAIL nop_hold: we=%b cwe=%b addr=%0d data=%h cout=%h, required 0 0 %0d %h %h",
               wb_we, wb_cout_we, wb_addr, wb_data, wb_cout, a, d, c);
    end
  endtask

  task automatic test_reset_mid_mul();
    offer(4'd7, 2'd2, 8'h03, 8'h05);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({wb_we, wb_cout_we, wb_addr, wb_data, wb_cout} !== '0) begin
      errors++;
      $display("FAIL midmul_reset_outputs: we=%b cwe=%b addr=%0d data=%h cout=%h, required all 0",
               wb_we, wb_cout_we, wb_addr, wb_data, wb_cout);
    end
    sb.delete();
    model_cout = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL midmul_recover: in_ready=%b pending=%0d, required 1 0", in_ready, sb.size());
    end
    offer(4'd0, 2'd1, 8'h02, 8'h03);
    @(negedge clk);
    checks++;
    if (wb_we !== 1'b1 || wb_data !== 8'h05 || wb_cout !== 8'h00) begin
      errors++;
      $display("FAIL midmul_after_add: we=%b data=%h cout=%h, required 1 05 00", wb_we, wb_data, wb_cout);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      offer(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    repeat (20) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL random_drain: pending=%0d, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_shift();
    test_mul_held();
    test_back_to_back();
    test_nop();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage that sits directly upstream of the register file.
- Accepts one decoded R-type operation per handshake, with the operand values already read from the register file.
- Computes the result and a carry/extension byte, and drives the register file's write port (rs destination) and its dedicated COUT port with one-cycle write pulses.
- Single-cycle ops sustain one per clock; MUL is an iterative shift-add that stalls the front end for DW cycles.

Parameters:
DW, 8, datapath width; also the MUL iteration count
AW, 2, rs destination address width (register-file count-1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered this cycle
- in_ready  out  1  stage can accept; equals (state==IDLE)
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL, 8 MOV, 9-15 NOP
- rs_addr  in  AW  destination register (also the left operand's source)
- rs_val  in  DW  left operand
- rt_val  in  DW  right operand
- wb_we  out  1  register-file write_enable pulse
- wb_cout_we  out  1  register-file cout_write_enable pulse
- wb_addr  out  AW  write address for wb_data
- wb_data  out  DW  result written to rs
- wb_cout  out  DW  value written to COUT

Behaviour:
Reset:
- Asynchronous on reset_n low.
- state=IDLE; counter=0; multiplier accumulators cleared.
- wb_we=0, wb_cout_we=0, wb_addr=0, wb_data=0, wb_cout=0.
- in_ready=1 after reset deasserts.

Handshake:
- An operation is accepted on a rising edge where in_valid && in_ready.
- in_valid while in_ready=0 is ignored; the requester must hold it.
- No input is captured without acceptance.

Write pulses:
- wb_we and wb_cout_we are registered and high for exactly one cycle per completed op; otherwise 0.
- wb_addr, wb_data and wb_cout hold their last value between pulses.

Single-cycle ops:
- Accepted at edge E0; results and enables are registered at E0 and visible in the following cycle.
- State stays IDLE, so back-to-back accepts yield back-to-back pulses.
- sh = rt_val[2:0]. All arithmetic is modulo 2^DW.
- ADD: data=rs+rt; cout={0..,carry}.
- SUB: data=rs-rt; cout=1 if rs<rt else 0.
- AND/OR/XOR: data=bitwise result; cout=0.
- SLL: data=rs<<sh; cout=rs>>(DW-sh), i.e. the bits shifted out, LSB-aligned; sh=0 gives cout=0.
- SRL: data=rs>>sh; cout=rs<<(DW-sh), i.e. the bits shifted out, MSB-aligned; sh=0 gives cout=0.
- MOV: data=rt; wb_we=1, wb_cout_we=0 (COUT untouched).
- NOP (9-15): no enables; the data outputs keep their previous values.
- All ops except MOV/NOP assert wb_cout_we; COUT is overwritten by every R-type op.

MUL state machine (IDLE -> MUL -> IDLE):
- At acceptance edge E0: latch rs_val, rt_val and rs_addr; clear the 2*DW accumulator; counter=0; go to MUL.
- Input changes after E0 have no effect.
- In MUL, each edge E1..E8 performs one shift-add step on bit counter of the multiplier, then increments counter.
- At E8 (counter==DW-1): register {wb_cout,wb_data} = rs*rt (full 2*DW product); pulse wb_we and wb_cout_we; return to IDLE.
- in_ready is low from E0 until E8; a new op can first be accepted at E9.
- The result pulse is visible in the cycle after E8.

Reset mid-MUL:
- The operation is abandoned.
- No write pulse is ever issued for it.
- Outputs return to their reset values.

Test Plan:
- ADD rs_val=0xF0, rt_val=0x20, rs_addr=2 -> next cycle: wb_we=1, wb_cout_we=1, wb_addr=2, wb_data=0x10, wb_cout=0x01; enables low the cycle after.
- SUB 0x05-0x07 -> wb_data=0xFE, wb_cout=0x01. SLL 0x81 by rt=0x09 (sh=1) -> wb_data=0x02, wb_cout=0x01. SRL 0x81 by 1 -> wb_data=0x40, wb_cout=0x80.
- MUL 0xFF*0xFF, operands changed to 0x00 one cycle after accept -> in_ready low 8 cycles; then single pulse with wb_data=0x01, wb_cout=0xFE.
- ADD held on in_valid during the MUL -> ignored until in_ready=1; accepted at E9 and its pulse follows the MUL pulse one cycle later.
- Three consecutive accepts ADD(1+1), XOR(0xFF^0x0F), MOV(rt=0x5A) -> three consecutive pulses with data 0x02, 0xF0, 0x5A; wb_cout_we = 1, 1, 0.
- reset_n low during MUL after 4 iterations -> all outputs 0 immediately, no write pulse; in_ready=1 after release. Separately, op=0xF -> no enables, data unchanged.
